icache_refill_way_dec: RTL and testbench
========================================

Name: icache_refill_way_dec

Overview:
- Refill-side way decoder for the icache data array.
- Accepts one refill request per line: a binary way index carrying a "none" flag in the MSB, plus a set index.
- Decodes the way index to a onehot data-array write enable and sequences BEAT_NUM refill beats into that way.
- On the last beat, signals line completion.

Parameters:
- WAY_NUM, 4, number of cache ways; a power of two, ≥2.
- WAY_W, $clog2(WAY_NUM), localparam; binary way index width.
- SET_IDX_W, 6, set index width.
- BEAT_NUM, 4, beats per cache line; a power of two, ≥2.
- BEAT_W, $clog2(BEAT_NUM), localparam.
- DATA_W, 128, beat data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  aborts any fill in progress.
- req_vld  in  1  refill request valid.
- req_rdy  out  1  request accepted when req_vld && req_rdy.
- req_way_bin  in  WAY_W+1  [WAY_W]=1 means no victim way; [WAY_W-1:0] is the way index.
- req_set_idx  in  SET_IDX_W  target set.
- beat_vld  in  1  refill beat valid.
- beat_rdy  out  1  beat accepted when beat_vld && beat_rdy.
- beat_data  in  DATA_W  beat payload.
- wr_en  out  1  data-array write strobe.
- wr_way_onehot  out  WAY_NUM  way write enable.
- wr_set_idx  out  SET_IDX_W  write set.
- wr_beat_idx  out  BEAT_W  write beat offset.
- wr_data  out  DATA_W  write data.
- done_vld  out  1  one-cycle pulse when the line is complete.
- done_way_onehot  out  WAY_NUM  way that was filled; all zero when bypassed.
- done_bypass  out  1  qualifies done_vld; the line was drained without any write.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs are 0 except req_rdy, which is 1.
  - Beat counter is 0; latched way and set are 0.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - req_rdy=1, beat_rdy=0.
  - On req_vld, latch req_set_idx and the way. Decode: way_onehot = 1<<req_way_bin[WAY_W-1:0] when [WAY_W]==0, else all zero.
  - An all-zero way_onehot sets the internal bypass flag.
  - Go to FILL and clear the beat counter.
- FILL:
  - req_rdy=0, beat_rdy=1.
  - Each accepted beat drives the write outputs one cycle later (registered):
    - wr_en = !bypass
    - wr_way_onehot = latched onehot
    - wr_set_idx = latched set
    - wr_beat_idx = counter value at acceptance
    - wr_data = beat_data
  - The counter then increments.
  - wr_en is 0 in every cycle with no accepted beat. wr_data/wr_beat_idx may hold stale values when wr_en=0.
  - Bypass: beats are still consumed and the counter still advances, but wr_en stays 0 and wr_way_onehot=0.
  - On acceptance of beat BEAT_NUM-1, the counter wraps to 0 and the state goes to DONE.
- DONE (exactly one cycle):
  - done_vld=1, done_way_onehot = latched onehot, done_bypass = bypass flag.
  - This cycle coincides with wr_en for the last beat.
  - req_rdy=0, beat_rdy=0.
  - Next state IDLE, so the minimum request-to-request spacing is BEAT_NUM+2 cycles.
- done_vld and done_bypass are 0 in all other states.
- Flush:
  - Priority over all other events in every state.
  - Next state IDLE; counter and bypass are cleared; no done pulse.
  - A beat presented in the flush cycle is not accepted (beat_rdy forced 0 while flush=1), and no write is generated for it.
  - A write already registered from the previous cycle still emits.
  - req_rdy is forced 0 while flush=1.
- Beat stalls: beat_vld low in FILL holds state and counter indefinitely; there is no timeout.
- A beat_vld in IDLE or DONE is ignored (beat_rdy=0).
- The block is decode-only: a single-bit wr_way_onehot is guaranteed. Onehot-ness is never checked on any input.

Test Plan:
- Normal fill: WAY_NUM=4, req_way_bin=3'b010, set=0x15, 4 back-to-back beats D0..D3 -> wr_en on 4 consecutive cycles starting 1 cycle after the first beat, wr_way_onehot=4'b0100, wr_beat_idx 0,1,2,3, wr_set_idx=0x15, wr_data D0..D3; done_vld pulse coincident with the last write, done_way_onehot=4'b0100, done_bypass=0; req_rdy back to 1 one cycle later.
- Bypass: req_way_bin=3'b100, 4 beats -> all 4 beats accepted, wr_en never asserted, done_vld=1 with done_way_onehot=0 and done_bypass=1.
- Stalled beats: way 3, beats with 2–5 idle cycles between them -> the counter holds across gaps; exactly 4 writes with wr_beat_idx 0..3; exactly one done pulse.
- Flush mid-fill: way 1, 2 beats accepted, then flush together with beat_vld -> only 2 writes (idx 0,1); no done; state IDLE with req_rdy=1 the cycle after flush drops. A new request for way 0 then fills with wr_beat_idx starting at 0.
- Reset mid-fill: assert rst asynchronously after beat 1 -> all outputs 0 and req_rdy=1 immediately, without waiting for clk; no write or done after release.
- Handshake gating: req_vld held high during FILL/DONE and beat_vld high in IDLE -> no second request latched and no beat consumed outside FILL; all ways 0..3 exercised, each giving the correct single-bit onehot.

Source files
------------

// File: rtl/icache_refill_way_dec.sv
// Refill-side way decoder: latches a victim way/set per request, then streams
// BEAT_NUM refill beats into the data array as registered, onehot-way writes.
module icache_refill_way_dec #(
    parameter  int WAY_NUM   = 4,
    parameter  int SET_IDX_W = 6,
    parameter  int BEAT_NUM  = 4,
    parameter  int DATA_W    = 128,
    localparam int WAY_W     = $clog2(WAY_NUM),
    localparam int BEAT_W    = $clog2(BEAT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [WAY_W:0]       req_way_bin,
    input  logic [SET_IDX_W-1:0] req_set_idx,
    input  logic                 beat_vld,
    output logic                 beat_rdy,
    input  logic [DATA_W-1:0]    beat_data,
    output logic                 wr_en,
    output logic [WAY_NUM-1:0]   wr_way_onehot,
    output logic [SET_IDX_W-1:0] wr_set_idx,
    output logic [BEAT_W-1:0]    wr_beat_idx,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 done_vld,
    output logic [WAY_NUM-1:0]   done_way_onehot,
    output logic                 done_bypass
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      cnt_q, cnt_d;
    logic [WAY_NUM-1:0]     way_q, way_d;
    logic [SET_IDX_W-1:0]   set_q, set_d;
    logic                   bypass_q, bypass_d;
    logic                   wr_en_q, wr_en_d;
    logic [WAY_NUM-1:0]     wr_way_q, wr_way_d;
    logic [SET_IDX_W-1:0]   wr_set_q, wr_set_d;
    logic [BEAT_W-1:0]      wr_beat_q, wr_beat_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;

    logic [WAY_NUM-1:0]     req_onehot;
    logic                   req_fire;
    logic                   beat_fire;

    // The MSB of req_way_bin means "no victim"; the decode then yields all zero.
    for (genvar g = 0; g < WAY_NUM; g++) begin : g_dec
        assign req_onehot[g] = !req_way_bin[WAY_W] &&
                               (req_way_bin[WAY_W-1:0] == WAY_W'(g));
    end

    always_comb begin
        req_rdy   = (state_q == IDLE) && !flush;
        beat_rdy  = (state_q == FILL) && !flush;
        req_fire  = req_vld && req_rdy;
        beat_fire = beat_vld && beat_rdy;

        state_d   = state_q;
        cnt_d     = cnt_q;
        way_d     = way_q;
        set_d     = set_q;
        bypass_d  = bypass_q;
        wr_en_d   = 1'b0;
        wr_way_d  = '0;
        wr_set_d  = wr_set_q;
        wr_beat_d = wr_beat_q;
        wr_data_d = wr_data_q;

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bypass_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        way_d    = req_onehot;
                        set_d    = req_set_idx;
                        bypass_d = ~|req_onehot;
                        cnt_d    = '0;
                        state_d  = FILL;
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        wr_en_d   = !bypass_q;
                        wr_way_d  = bypass_q ? '0 : way_q;
                        wr_set_d  = set_q;
                        wr_beat_d = cnt_q;
                        wr_data_d = beat_data;
                        // Power-of-two beat count: the increment wraps to 0 on the last beat.
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == BEAT_W'(BEAT_NUM - 1)) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            way_q     <= '0;
            set_q     <= '0;
            bypass_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_way_q  <= '0;
            wr_set_q  <= '0;
            wr_beat_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            way_q     <= way_d;
            set_q     <= set_d;
            bypass_q  <= bypass_d;
            wr_en_q   <= wr_en_d;
            wr_way_q  <= wr_way_d;
            wr_set_q  <= wr_set_d;
            wr_beat_q <= wr_beat_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_way_onehot = wr_way_q;
    assign wr_set_idx    = wr_set_q;
    assign wr_beat_idx   = wr_beat_q;
    assign wr_data       = wr_data_q;

    // A flush landing on the DONE cycle suppresses the completion pulse.
    assign done_vld        = (state_q == DONE) && !flush;
    assign done_way_onehot = done_vld ? way_q : '0;
    assign done_bypass     = done_vld && bypass_q;

endmodule

// File: tb/tb_icache_refill_way_dec.sv
// Scoreboard bench: a line-level reference model queues expected writes and
// completions; an independent monitor pops and compares them as they appear.
module tb_icache_refill_way_dec;

    localparam int WAY_NUM   = 4;
    localparam int WAY_W     = 2;
    localparam int SET_IDX_W = 6;
    localparam int BEAT_NUM  = 4;
    localparam int BEAT_W    = 2;
    localparam int DATA_W    = 128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 req_vld;
    logic                 req_rdy;
    logic [WAY_W:0]       req_way_bin;
    logic [SET_IDX_W-1:0] req_set_idx;
    logic                 beat_vld;
    logic                 beat_rdy;
    logic [DATA_W-1:0]    beat_data;
    logic                 wr_en;
    logic [WAY_NUM-1:0]   wr_way_onehot;
    logic [SET_IDX_W-1:0] wr_set_idx;
    logic [BEAT_W-1:0]    wr_beat_idx;
    logic [DATA_W-1:0]    wr_data;
    logic                 done_vld;
    logic [WAY_NUM-1:0]   done_way_onehot;
    logic                 done_bypass;

    icache_refill_way_dec #(
        .WAY_NUM(WAY_NUM), .SET_IDX_W(SET_IDX_W), .BEAT_NUM(BEAT_NUM), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_way_bin(req_way_bin), .req_set_idx(req_set_idx),
        .beat_vld(beat_vld), .beat_rdy(beat_rdy), .beat_data(beat_data),
        .wr_en(wr_en), .wr_way_onehot(wr_way_onehot), .wr_set_idx(wr_set_idx),
        .wr_beat_idx(wr_beat_idx), .wr_data(wr_data),
        .done_vld(done_vld), .done_way_onehot(done_way_onehot), .done_bypass(done_bypass)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic [WAY_NUM-1:0]   way;
        logic [SET_IDX_W-1:0] set;
        int                   beat;
        logic [DATA_W-1:0]    data;
    } wr_exp_t;

    typedef struct {
        int                 cyc;
        logic [WAY_NUM-1:0] way;
        bit                 bypass;
    } done_exp_t;

    wr_exp_t   wq[$];
    done_exp_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Line-level model: is a line open, how many beats it has taken, and which way/set it owns.
    bit                   m_line_open;
    bit                   m_done_now;
    int                   m_beats;
    logic [WAY_NUM-1:0]   m_way;
    logic [SET_IDX_W-1:0] m_set;
    bit                   m_bypass;

    function automatic void chk(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_line_open = 0;
        m_done_now  = 0;
        m_beats     = 0;
        m_way       = '0;
        m_set       = '0;
        m_bypass    = 0;
        wq.delete();
        dq.delete();
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Evaluated mid-cycle with inputs settled; predicts handshakes and queues outputs.
    function automatic void model_eval();
        wr_exp_t   w;
        done_exp_t d;
        chk("req_rdy",  req_rdy,  !flush && !m_line_open && !m_done_now);
        chk("beat_rdy", beat_rdy, !flush && m_line_open);
        if (flush) begin
            m_line_open = 0;
            m_done_now  = 0;
            m_beats     = 0;
        end else if (m_done_now) begin
            d.cyc = cyc; d.way = m_way; d.bypass = m_bypass;
            dq.push_back(d);
            m_done_now = 0;
        end else if (m_line_open) begin
            if (beat_vld) begin
                if (!m_bypass) begin
                    w.cyc = cyc + 1; w.way = m_way; w.set = m_set;
                    w.beat = m_beats; w.data = beat_data;
                    wq.push_back(w);
                end
                m_beats++;
                if (m_beats == BEAT_NUM) begin
                    m_line_open = 0;
                    m_done_now  = 1;
                    m_beats     = 0;
                end
            end
        end else if (req_vld) begin
            m_way       = req_way_bin[WAY_W] ? '0 : WAY_NUM'(1 << int'(req_way_bin[WAY_W-1:0]));
            m_set       = req_set_idx;
            m_bypass    = (m_way == '0);
            m_line_open = 1;
            m_beats     = 0;
        end
    endfunction

    task automatic cycle(input bit rv, input logic [WAY_W:0] wb, input logic [SET_IDX_W-1:0] st,
                         input bit bv, input logic [DATA_W-1:0] dat, input bit fl);
        req_vld = rv; req_way_bin = wb; req_set_idx = st;
        beat_vld = bv; beat_data = dat; flush = fl;
        #1;
        model_eval();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, 0);
    endtask

    task automatic fill_line(input logic [WAY_W:0] wb, input logic [SET_IDX_W-1:0] st,
                             input int gap_min, input int gap_max);
        cycle(1, wb, st, 0, '0, 0);
        for (int b = 0; b < BEAT_NUM; b++) begin
            cycle(0, '0, '0, 1, rnd_data(), 0);
            if (gap_max > 0) idle(int'($urandom_range(gap_max, gap_min)));
        end
        idle(2);
    endtask

    // Monitor: pops expectations only when the DUT presents an output.
    always @(negedge clk) begin
        wr_exp_t   w;
        done_exp_t d;
        #2;
        if (!rst) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got wr_en=1 beat %0d expected no write (cycle %0d)",
                             wr_beat_idx, cyc);
                end else begin
                    w = wq.pop_front();
                    chk("wr_cycle", DATA_W'(cyc), DATA_W'(w.cyc));
                    chk("wr_way", DATA_W'(wr_way_onehot), DATA_W'(w.way));
                    chk("wr_set", DATA_W'(wr_set_idx), DATA_W'(w.set));
                    chk("wr_beat", DATA_W'(wr_beat_idx), DATA_W'(w.beat));
                    chk("wr_data", wr_data, w.data);
                end
            end else begin
                chk("wr_way_idle", DATA_W'(wr_way_onehot), '0);
                if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                    w = wq.pop_front();
                    chk("wr_missing", DATA_W'(wr_en), DATA_W'(1));
                end
            end
            if (done_vld) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done_vld=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", DATA_W'(cyc), DATA_W'(d.cyc));
                    chk("done_way", DATA_W'(done_way_onehot), DATA_W'(d.way));
                    chk("done_bypass", DATA_W'(done_bypass), DATA_W'(d.bypass));
                end
            end else begin
                chk("done_idle", DATA_W'({done_way_onehot, done_bypass}), '0);
                if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    d = dq.pop_front();
                    chk("done_missing", DATA_W'(done_vld), DATA_W'(1));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"},  DATA_W'(req_rdy), DATA_W'(1));
        chk({tag, "_beat_rdy"}, DATA_W'(beat_rdy), '0);
        chk({tag, "_wr"}, DATA_W'({wr_en, wr_way_onehot, wr_set_idx, wr_beat_idx}), '0);
        chk({tag, "_wr_data"}, wr_data, '0);
        chk({tag, "_done"}, DATA_W'({done_vld, done_way_onehot, done_bypass}), '0);
    endtask

    initial begin
        rst = 1'b1; flush = 0; req_vld = 0; req_way_bin = '0; req_set_idx = '0;
        beat_vld = 0; beat_data = '0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Normal fill, way 2, set 0x15, back-to-back beats.
        fill_line(3'b010, 6'h15, 0, 0);
        // Bypass line: beats drained, no writes, done_bypass set.
        fill_line(3'b100, 6'h2a, 0, 0);
        // Stalled beats into way 3.
        fill_line(3'b011, 6'h07, 2, 5);

        // Flush mid-fill, then a fresh request must restart at beat 0.
        cycle(1, 3'b001, 6'h11, 0, '0, 0);
        cycle(0, '0, '0, 1, rnd_data(), 0);
        cycle(0, '0, '0, 1, rnd_data(), 0);
        cycle(0, '0, '0, 1, rnd_data(), 1);
        idle(1);
        fill_line(3'b000, 6'h3c, 0, 0);

        // Asynchronous reset mid-fill, away from any clock edge.
        cycle(1, 3'b010, 6'h21, 0, '0, 0);
        cycle(0, '0, '0, 1, rnd_data(), 0);
        cycle(0, '0, '0, 0, '0, 0);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        idle(3);

        // Handshake gating: req_vld and beat_vld held high together across all ways.
        for (int w = 0; w < WAY_NUM; w++) begin
            for (int i = 0; i < BEAT_NUM + 3; i++)
                cycle(1, (WAY_W+1)'(w), SET_IDX_W'(w * 9 + 1), 1, rnd_data(), 0);
        end
        idle(3);

        // Randomised traffic with occasional flushes and stalls.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 2) == 0, (WAY_W+1)'($urandom), SET_IDX_W'($urandom),
                  ($urandom % 10) < 7, rnd_data(), ($urandom % 40) == 0);
        idle(6);

        chk("wq_drained", DATA_W'(wq.size()), '0);
        chk("dq_drained", DATA_W'(dq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
